// File: rtl/seq_mem_d1_initiator.sv
// seq_mem_d1_initiator
//   Master-side sequencer for a single-port sequential memory (seq_mem_d1).
//   It takes burst read/write commands over valid/ready. Write beats stream
//   in on wr_*, and read words stream out on rsp_*. Only one memory access
//   is outstanding at a time, and read and write strobes are never high
//   together.
//
// Optional feature: define SEQ_MEM_BOUNDS_CHECK_EN to suppress accesses with
//   address >= SIZE. Such reads return 0 and such write beats are discarded.
//   Either case raises cmd_err alongside cmd_done. Without the macro every
//   address is issued unchanged and cmd_err is tied to 0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_*               burst command (write flag, start addr, len = words-1)
//   wr_valid/ready/data write beat stream (ready only while waiting for a beat)
//   rsp_valid/ready/    read word stream; rsp_last marks the final word
//     data/last
//   cmd_done, cmd_err   one-cycle completion pulse, error qualifier
//   mem_*               seq_mem_d1 interface (addr0, read_en, write_en, in,
//                       out, read_done, write_done)
module seq_mem_d1_initiator #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 64,
    parameter int IDX_SIZE = 8,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [IDX_SIZE-1:0] cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_last,
    output logic                cmd_done,
    output logic                cmd_err,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [WIDTH-1:0]    mem_in,
    input  logic [WIDTH-1:0]    mem_out,
    input  logic                mem_read_done,
    input  logic                mem_write_done
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, RSP, WR_DATA, WR_WAIT, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_SIZE-1:0] cur_addr, cur_addr_nxt;
    logic [LEN_W-1:0]    remaining, remaining_nxt;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_nxt;
    logic [IDX_SIZE-1:0] addr_inc;

    // Natural-width add: wraps modulo 2^IDX_SIZE.
    assign addr_inc = cur_addr + IDX_SIZE'(1);

    // Out-of-bounds flags for the command address, the next address of a
    // read burst, and the current address of a write beat.
    logic oob_cmd, oob_inc, oob_cur;

`ifdef SEQ_MEM_BOUNDS_CHECK_EN
    function automatic logic addr_oob(input logic [IDX_SIZE-1:0] a);
        return 32'(a) >= 32'(SIZE);
    endfunction

    assign oob_cmd = addr_oob(cmd_addr);
    assign oob_inc = addr_oob(addr_inc);
    assign oob_cur = addr_oob(cur_addr);

    // Sticky error: cleared when a command is accepted, set by any skipped
    // word. A read whose first word is out of range sets it at acceptance.
    logic err_q;
    logic err_clr, err_set;

    assign err_clr = (state == IDLE) && cmd_valid;
    assign err_set = ((state == IDLE) && cmd_valid && !cmd_write && oob_cmd)
                   | ((state == RSP) && rsp_ready && (remaining != '0) && oob_inc)
                   | ((state == WR_DATA) && wr_valid && oob_cur);

    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
    end

    assign cmd_err = (state == DONE) && err_q;
`else
    assign oob_cmd = 1'b0;
    assign oob_inc = 1'b0;
    assign oob_cur = 1'b0;
    assign cmd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            rsp_data_q <= '0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= cur_addr_nxt;
            remaining  <= remaining_nxt;
            rsp_data_q <= rsp_data_nxt;
        end
    end

    assign rsp_data = rsp_data_q;

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        rsp_data_nxt  = rsp_data_q;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rsp_valid     = 1'b0;
        rsp_last      = 1'b0;
        cmd_done      = 1'b0;
        mem_addr0     = '0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_in        = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_nxt  = cmd_addr;
                    remaining_nxt = cmd_len;
                    if (cmd_write) begin
                        state_nxt = WR_DATA;
                    end else if (oob_cmd) begin
                        rsp_data_nxt = '0;
                        state_nxt    = RSP;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                mem_read_en = 1'b1;
                mem_addr0   = cur_addr;
                state_nxt   = RD_WAIT;
            end
            RD_WAIT: begin
                mem_addr0 = cur_addr;
                if (mem_read_done) begin
                    rsp_data_nxt = mem_out;
                    state_nxt    = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = (remaining == '0);
                if (rsp_ready) begin
                    if (remaining == '0) begin
                        state_nxt = DONE;
                    end else begin
                        remaining_nxt = remaining - LEN_W'(1);
                        cur_addr_nxt  = addr_inc;
                        if (oob_inc) begin
                            // Skipped word goes straight back out as zero.
                            rsp_data_nxt = '0;
                            state_nxt    = RSP;
                        end else begin
                            state_nxt = RD_ISSUE;
                        end
                    end
                end
            end
            WR_DATA: begin
                wr_ready  = 1'b1;
                mem_addr0 = cur_addr;
                if (wr_valid) begin
                    if (!oob_cur) begin
                        mem_write_en = 1'b1;
                        mem_in       = wr_data;
                        state_nxt    = WR_WAIT;
                    end else if (remaining == '0) begin
                        state_nxt = DONE;
                    end else begin
                        // Beat consumed and dropped; stay for the next one.
                        remaining_nxt = remaining - LEN_W'(1);
                        cur_addr_nxt  = addr_inc;
                    end
                end
            end
            WR_WAIT: begin
                mem_addr0 = cur_addr;
                if (mem_write_done) begin
                    if (remaining == '0) begin
                        state_nxt = DONE;
                    end else begin
                        remaining_nxt = remaining - LEN_W'(1);
                        cur_addr_nxt  = addr_inc;
                        state_nxt     = WR_DATA;
                    end
                end
            end
            DONE: begin
                cmd_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_mem_d1_initiator.sv
// Bench for seq_mem_d1_initiator. A behavioural seq_mem_d1 (one-cycle
// done) backs the DUT. Expected writes, read addresses, read words and
// cmd_err values are queued when stimulus is driven. A negedge monitor pops
// and compares each one as the DUT produces it.
module tb_seq_mem_d1_initiator;

    localparam int WIDTH = 32, SIZE = 64, IDX_SIZE = 8, LEN_W = 8;
`ifdef SEQ_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [IDX_SIZE-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]    cmd_len = '0;
    logic                wr_valid = 1'b0, wr_ready;
    logic [WIDTH-1:0]    wr_data = '0;
    logic                rsp_valid, rsp_ready = 1'b0, rsp_last;
    logic [WIDTH-1:0]    rsp_data;
    logic                cmd_done, cmd_err;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic                mem_read_en, mem_write_en;
    logic [WIDTH-1:0]    mem_in, mem_out = '0;
    logic                mem_read_done = 1'b0, mem_write_done = 1'b0;

    seq_mem_d1_initiator #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .cmd_done(cmd_done), .cmd_err(cmd_err),
        .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_in(mem_in), .mem_out(mem_out),
        .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory. stall_wr withholds write_done to park the DUT in WR_WAIT.
    logic [WIDTH-1:0] mem [0:255];
    logic             mem_clr = 1'b1, stall_wr = 1'b0;
    always @(posedge clk) begin
        mem_read_done  <= 1'b0;
        mem_write_done <= 1'b0;
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (mem_write_en) begin
                mem[mem_addr0] <= mem_in;
                mem_write_done <= !stall_wr;
            end
            if (mem_read_en) begin
                mem_out       <= mem[mem_addr0];
                mem_read_done <= 1'b1;
            end
        end
    end

    // Scoreboard
    typedef struct packed { logic [7:0] a; logic [31:0] d; } wexp_t;
    typedef struct packed { logic [31:0] d; logic last; } rexp_t;
    wexp_t      wq[$];
    rexp_t      rq[$];
    logic [7:0] raq[$];
    logic       eq[$];
    int         rsp_cyc[$];
    logic [31:0] ref_mem [0:255];

    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, rd_cnt = 0, hs_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic oob(input logic [7:0] a);
        return BOUNDS && (32'(a) >= 32'(SIZE));
    endfunction

    function automatic logic any_oob(input logic [7:0] a, input logic [7:0] l);
        logic r = 1'b0;
        for (int i = 0; i <= int'(l); i++) r = r | oob(a + 8'(i));
        return r;
    endfunction

    // Monitor
    wexp_t mon_w;
    rexp_t mon_r;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read_en || mem_write_en)
                check("rw_exclusive", 32'(mem_read_en & mem_write_en), 32'd0);
            if (mem_write_en) begin
                if (wq.size() == 0) fail_evt("unexpected mem write");
                else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 32'(mem_addr0), 32'(mon_w.a));
                    check("wr_data", mem_in, mon_w.d);
                end
            end
            if (mem_read_en) begin
                rd_cnt++;
                if (raq.size() == 0) fail_evt("unexpected mem read");
                else check("rd_addr", 32'(mem_addr0), 32'(raq.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                if (rq.size() == 0) fail_evt("unexpected rsp word");
                else begin
                    mon_r = rq.pop_front();
                    check("rsp_data", rsp_data, mon_r.d);
                    check("rsp_last", 32'(rsp_last), 32'(mon_r.last));
                end
            end
            if (cmd_done) begin
                done_cnt++;
                if (eq.size() == 0) fail_evt("unexpected cmd_done");
                else check("cmd_err", 32'(cmd_err), 32'(eq.pop_front()));
            end
        end
    end

    // Drivers (called right after a posedge + #1)
    task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
        int k = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) fail_evt("cmd_ready timeout");
        hs_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin @(negedge clk); k++; end
        if (done_cnt == d0) fail_evt({name, " cmd_done timeout"});
        @(negedge clk);
        @(posedge clk); #1;
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_write(input logic [7:0] a, input logic [7:0] l, input logic [31:0] base,
                             input logic exp_err);
        int d0 = done_cnt;
        logic [7:0] ad;
        eq.push_back(exp_err);
        issue_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            int k = 0;
            ad = a + 8'(i);
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            if (!oob(ad)) begin
                wq.push_back('{a: ad, d: wr_data});
                ref_mem[ad] = wr_data;
            end
            @(negedge clk);
            while (!wr_ready && k < 50) begin @(negedge clk); k++; end
            if (!wr_ready) begin
                fail_evt("wr_ready timeout");
                wr_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wr_data  = '0;
        wait_done(d0, 8 * (int'(l) + 1) + 20, "wr");
    endtask

    task automatic push_read(input logic [7:0] a, input logic [7:0] l, input logic exp_err);
        logic [7:0] ad;
        rexp_t re;
        for (int i = 0; i <= int'(l); i++) begin
            ad      = a + 8'(i);
            re.d    = oob(ad) ? 32'd0 : ref_mem[ad];
            re.last = (i == int'(l));
            rq.push_back(re);
            if (!oob(ad)) raq.push_back(ad);
        end
        eq.push_back(exp_err);
    endtask

    task automatic run_read(input logic [7:0] a, input logic [7:0] l, input logic exp_err);
        int d0 = done_cnt;
        push_read(a, l, exp_err);
        rsp_ready = 1'b1;
        issue_cmd(1'b0, a, l);
        wait_done(d0, 8 * (int'(l) + 1) + 20, "rd");
    endtask

    typedef struct { logic w; logic [7:0] a; logic [7:0] l; logic [31:0] base; logic exp_err; } vec_t;
    vec_t vt [10];

    initial begin
        int d0, r0, k;
        logic [31:0] held;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        vt[0] = '{1'b1, 8'h04, 8'h02, 32'h0000000A, any_oob(8'h04, 8'h02)};
        vt[1] = '{1'b0, 8'h04, 8'h02, 32'h0,        any_oob(8'h04, 8'h02)};
        vt[2] = '{1'b1, 8'hFF, 8'h01, 32'h00000100, any_oob(8'hFF, 8'h01)};
        vt[3] = '{1'b0, 8'hFF, 8'h01, 32'h0,        any_oob(8'hFF, 8'h01)};
        vt[4] = '{1'b1, 8'h10, 8'h00, 32'hCAFE0000, any_oob(8'h10, 8'h00)};
        vt[5] = '{1'b0, 8'h10, 8'h00, 32'h0,        any_oob(8'h10, 8'h00)};
        vt[6] = '{1'b1, 8'h3C, 8'h07, 32'h12340000, any_oob(8'h3C, 8'h07)};
        vt[7] = '{1'b0, 8'h3C, 8'h07, 32'h0,        any_oob(8'h3C, 8'h07)};
        vt[8] = '{1'b1, 8'h00, 8'hFF, 32'h00010000, any_oob(8'h00, 8'hFF)};
        vt[9] = '{1'b0, 8'h00, 8'hFF, 32'h0,        any_oob(8'h00, 8'hFF)};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready",  32'(wr_ready),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last",  32'(rsp_last),  32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_cmd_done",  32'(cmd_done),  32'd0);
        check("rst_cmd_err",   32'(cmd_err),   32'd0);
        check("rst_mem_strb",  32'({mem_read_en, mem_write_en}), 32'd0);
        check("rst_mem_addr",  32'(mem_addr0), 32'd0);
        check("rst_mem_in",    mem_in,         32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        // Table-driven bursts
        for (int i = 0; i < 10; i++) begin
            if (vt[i].w) run_write(vt[i].a, vt[i].l, vt[i].base, vt[i].exp_err);
            else         run_read(vt[i].a, vt[i].l, vt[i].exp_err);
        end

        // Rewrite 4..6 with A,B,C, then check first-word latency and 3-cycle spacing
        run_write(8'h04, 8'h02, 32'h0000000A, 1'b0);
        rsp_cyc.delete();
        run_read(8'h04, 8'h02, 1'b0);
        check("rsp_count", 32'(rsp_cyc.size()), 32'd3);
        if (rsp_cyc.size() == 3)
            for (int i = 0; i < 3; i++)
                check("rsp_timing", 32'(rsp_cyc[i] - hs_cyc), 32'(3 * (i + 1)));

        // Backpressure: word held stable, no further read issued while stalled
        d0 = done_cnt;
        push_read(8'h04, 8'h01, 1'b0);
        rsp_ready = 1'b0;
        issue_cmd(1'b0, 8'h04, 8'h01);
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        if (!rsp_valid) fail_evt("bp rsp_valid timeout");
        r0 = rd_cnt;
        held = ref_mem[8'h04];
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  rsp_data,       held);
            check("bp_no_reread", 32'(rd_cnt - r0), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_done(d0, 40, "bp");

        // Reset while parked in WR_WAIT of a 4-word burst
        d0 = done_cnt;
        stall_wr = 1'b1;
        issue_cmd(1'b1, 8'h30, 8'h03);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD0030;
        wq.push_back('{a: 8'h30, d: wr_data});
        ref_mem[8'h30] = wr_data;
        @(negedge clk);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_wr_ready",  32'(wr_ready),  32'd0);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; stall_wr = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_wr_ready",  32'(wr_ready),  32'd0);
        check("mid_rst_strobes",   32'({mem_read_en, mem_write_en}), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk); #1;
        run_read(8'h30, 8'h00, 1'b0);

`ifdef SEQ_MEM_BOUNDS_CHECK_EN
        // Straddle the top of memory: only 62 and 63 reach the memory
        r0 = rd_cnt;
        run_read(8'd62, 8'd3, 1'b1);
        check("oob_rd_count", 32'(rd_cnt - r0), 32'd2);
`endif

        check("wq_drained",  32'(wq.size()),  32'd0);
        check("rq_drained",  32'(rq.size()),  32'd0);
        check("raq_drained", 32'(raq.size()), 32'd0);
        check("eq_drained",  32'(eq.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule
